// File: rtl/als_sampler_pkg.sv
// Shared types and helpers for the ALS sampling scheduler and its averaging ring.
package als_sampler_pkg;

  localparam int unsigned AlsDataW = 8;

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StTrig  = 2'd1,
    StBusy  = 2'd2,
    StAccum = 2'd3
  } state_e;

  // LED i lights once the level reaches the middle of its 32-wide bucket.
  function automatic logic [7:0] therm_leds(input logic [AlsDataW-1:0] lvl);
    logic [7:0] bar;
    bar = '0;
    for (int i = 0; i < 8; i++) begin
      bar[i] = ({1'b0, lvl} >= 9'(32 * i + 16));
    end
    return bar;
  endfunction

endpackage

// File: rtl/als_avg_ring.sv
// Moving-average ring: keeps the last 2^AvgLog2 samples and their running sum.
module als_avg_ring
  import als_sampler_pkg::*;
#(
  parameter int unsigned AvgLog2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AlsDataW-1:0] din,
  output logic [AlsDataW-1:0] avg
);

  localparam int unsigned Depth = 1 << AvgLog2;
  localparam int unsigned SumW  = AvgLog2 + AlsDataW;

  logic [AlsDataW-1:0] ring_q [Depth];
  logic [AvgLog2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SumW-1:0]     sum_q, sum_d;

  // Sum width covers 255 * Depth, so the subtract-then-add never wraps.
  always_comb begin
    sum_d    = sum_q - SumW'(ring_q[wr_ptr_q]) + SumW'(din);
    wr_ptr_d = wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else if (wr_en) begin
      ring_q[wr_ptr_q] <= din;
      wr_ptr_q         <= wr_ptr_d;
      sum_q            <= sum_d;
    end
  end

  assign avg = sum_q[SumW-1:AvgLog2];

endmodule

// File: rtl/als_sampler.sv
// Periodic ALS read scheduler: triggers the reader, averages its results and drives
// a level output with valid strobe plus an 8-LED thermometer bar.
module als_sampler
  import als_sampler_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD  = 5_000_000,
  parameter int unsigned AVG_LOG2       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                als_ready,
  input  logic                als_done,
  input  logic [AlsDataW-1:0] als_data,
  output logic                als_initiate,
  output logic [AlsDataW-1:0] level,
  output logic                level_valid,
  output logic [7:0]          leds,
  output logic                timeout_err
);

  localparam int unsigned PerW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [PerW-1:0]     per_cnt_q, per_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                initiate_q, initiate_d;
  logic                tmo_err_q, tmo_err_d;
  logic [AlsDataW-1:0] sample_q, sample_d;
  logic                upd_q;
  logic [AlsDataW-1:0] level_q;
  logic                level_valid_q;
  logic [AlsDataW-1:0] avg;
  logic                tmo_last;

  assign tmo_last = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    initiate_d = 1'b0;
    tmo_err_d  = tmo_err_q;
    sample_d   = sample_q;
    unique case (state_q)
      StWait: begin
        tmo_cnt_d = '0;
        if (!enable) begin
          per_cnt_d = '0;
        end else if (per_cnt_q == PerW'(SAMPLE_PERIOD - 1)) begin
          per_cnt_d = '0;
          state_d   = StTrig;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      // No done can arrive before initiate, so an expiring budget beats a late ready.
      StTrig: begin
        if (tmo_last) begin
          tmo_err_d = 1'b1;
          state_d   = StWait;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (als_ready) begin
            initiate_d = 1'b1;
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        if (als_done) begin
          sample_d = als_data;
          state_d  = StAccum;
        end else if (tmo_last) begin
          tmo_err_d = 1'b1;
          state_d   = StWait;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StAccum: state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWait;
      per_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      initiate_q    <= 1'b0;
      tmo_err_q     <= 1'b0;
      sample_q      <= '0;
      upd_q         <= 1'b0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      initiate_q    <= initiate_d;
      tmo_err_q     <= tmo_err_d;
      sample_q      <= sample_d;
      upd_q         <= (state_q == StAccum);
      level_valid_q <= upd_q;
      if (upd_q) begin
        level_q <= avg;
      end
    end
  end

  als_avg_ring #(
    .AvgLog2(AVG_LOG2)
  ) u_ring (
    .clk  (clk),
    .reset(reset),
    .wr_en(state_q == StAccum),
    .din  (sample_q),
    .avg  (avg)
  );

  assign als_initiate = initiate_q;
  assign level        = level_q;
  assign level_valid  = level_valid_q;
  assign timeout_err  = tmo_err_q;
  assign leds         = therm_leds(level_q);

endmodule

// File: tb/tb_als_sampler.sv
// Bench for als_sampler: behavioural ALS reader, moving-average scoreboard, timing checks.
module tb_als_sampler;

  localparam int Period = 16;
  localparam int AvgLog2 = 2;
  localparam int Tmo = 64;
  localparam int RdLat = 20;
  localparam int Window = 1 << AvgLog2;

  logic       clk = 1'b0;
  logic       reset, enable, als_ready, als_done, als_initiate, level_valid, timeout_err;
  logic [7:0] als_data, level, leds;

  als_sampler #(
    .SAMPLE_PERIOD (Period),
    .AVG_LOG2      (AvgLog2),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .als_ready   (als_ready),
    .als_done    (als_done),
    .als_data    (als_data),
    .als_initiate(als_initiate),
    .level       (level),
    .level_valid (level_valid),
    .leds        (leds),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: level is the truncated mean of the last Window readings, zeros before.
  int readings[$];
  int exp_q[$];
  int due_q[$];
  int last_done_edge = -1;

  function automatic int expected_avg();
    int s;
    s = 0;
    for (int k = 0; k < Window && k < readings.size(); k++) begin
      s += readings[readings.size() - 1 - k];
    end
    return s / Window;
  endfunction

  function automatic logic [31:0] expected_leds(input int lvl);
    int lit;
    lit = (lvl + 16) / 32;
    return (32'd1 << lit) - 32'd1;
  endfunction

  // Behavioural ALS reader: busy for RdLat cycles after initiate, then pulses done.
  bit         rd_busy = 0, rd_orphan = 0, rd_never_done = 0, rd_hold_low = 0;
  int         rd_cnt = 0;
  logic [7:0] rd_d;
  logic [7:0] data_q[$];

  assign als_ready = !rd_busy && !rd_hold_low;

  always @(negedge clk) begin
    als_done = 1'b0;
    als_data = 8'($urandom);
    if (rd_busy) begin
      rd_cnt++;
      if (rd_cnt == RdLat) begin
        rd_busy = 0;
        if (!rd_never_done) begin
          if (rd_orphan || reset || data_q.size() == 0) rd_d = 8'($urandom);
          else rd_d = data_q.pop_front();
          als_done = 1'b1;
          als_data = rd_d;
          if (!rd_orphan && !reset) begin
            readings.push_back(int'(rd_d));
            exp_q.push_back(expected_avg());
            due_q.push_back(cyc + 3);
            last_done_edge = cyc + 1;
          end
        end
        rd_orphan = 0;
      end
    end else if (als_initiate) begin
      rd_busy = 1;
      rd_cnt  = 0;
    end
  end

  // Output monitor.
  bit init_prev = 0, tmo_prev = 0, gap_chk = 0;
  int n_init = 0, n_valid = 0, last_init_edge = -1, tmo_rise_edge = -1;
  int mon_e, mon_due;

  always @(negedge clk) begin
    if (als_initiate) begin
      check_eq("init_width", 32'(init_prev), 0);
      if (!init_prev) begin
        n_init++;
        last_init_edge = cyc;
        if (gap_chk && last_done_edge >= 0) check_eq("init_gap", cyc - last_done_edge, Period + 2);
      end
    end
    init_prev = als_initiate;
    if (timeout_err && !tmo_prev) tmo_rise_edge = cyc;
    tmo_prev = timeout_err;
    if (level_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(level_valid), 0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_due = due_q.pop_front();
        check_eq("level", level, mon_e);
        check_eq("leds", leds, expected_leds(mon_e));
        check_eq("latency", cyc, mon_due);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valids(input int n, input int budget);
    int tgt, t;
    tgt = n_valid + n;
    t   = 0;
    while (n_valid < tgt && t < budget) begin
      tick();
      t++;
    end
    check_eq("valid_wait", n_valid, tgt);
  endtask

  task automatic wait_init(input int budget);
    int tgt, t;
    tgt = n_init + 1;
    t   = 0;
    while (n_init < tgt && t < budget) begin
      tick();
      t++;
    end
    check_eq("init_wait", n_init, tgt);
  endtask

  task automatic wait_tmo(input int budget);
    int t;
    t = 0;
    while (!timeout_err && t < budget) begin
      tick();
      t++;
    end
    check_eq("tmo_wait", 32'(timeout_err), 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rst_level", level, 0);
    check_eq("rst_leds", leds, 0);
    check_eq("rst_valid", 32'(level_valid), 0);
    check_eq("rst_initiate", 32'(als_initiate), 0);
    check_eq("rst_timeout", 32'(timeout_err), 0);
    readings.delete();
    exp_q.delete();
    due_q.delete();
    last_done_edge = -1;
    if (rd_busy) rd_orphan = 1;
    reset = 1'b0;
  endtask

  int i0, v0, r, ie, c0;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    als_done = 1'b0;
    als_data = 8'h00;
    apply_reset();

    // Constant 0x40 readings: levels ramp 0x10..0x40 while the ring warms up.
    repeat (5) data_q.push_back(8'h40);
    gap_chk = 1;
    enable  = 1'b1;
    wait_valids(5, 400);
    check_eq("ramp_final", level, 8'h40);

    // Reset while a read is in flight; the late done must be ignored.
    wait_init(100);
    repeat (5) tick();
    apply_reset();

    // 0x80 x4 then 0x00 x4 walks the write pointer through a full wrap.
    repeat (4) data_q.push_back(8'h80);
    repeat (4) data_q.push_back(8'h00);
    wait_valids(8, 600);
    check_eq("wrap_leds", leds, 0);

    repeat (12) data_q.push_back(8'($urandom));
    wait_valids(12, 900);

    // Drop enable during a read: it completes, then nothing more is issued.
    gap_chk = 0;
    wait_init(100);
    repeat (5) tick();
    enable = 1'b0;
    v0 = n_valid;
    wait_valids(1, 100);
    i0 = n_init;
    repeat (200) tick();
    check_eq("idle_no_init", n_init, i0);
    check_eq("idle_one_valid", n_valid, v0 + 1);

    // Ready held low for 30 cycles in trigger: initiate waits for it.
    rd_hold_low = 1;
    enable = 1'b1;
    repeat (46) tick();
    check_eq("hold_no_init", n_init, i0);
    check_eq("hold_no_tmo", 32'(timeout_err), 0);
    rd_hold_low = 0;
    r = cyc;
    wait_init(10);
    check_eq("hold_release", last_init_edge, r + 1);
    wait_valids(1, 100);

    // Reader never answers: timeout after Tmo cycles, no update, retrigger after Period.
    rd_never_done = 1;
    wait_init(100);
    ie = last_init_edge;
    v0 = n_valid;
    wait_tmo(200);
    check_eq("tmo_delay", tmo_rise_edge - (ie - 1), Tmo);
    wait_init(100);
    check_eq("tmo_reinit", last_init_edge - tmo_rise_edge, Period + 1);
    check_eq("tmo_no_valid", n_valid, v0);
    rd_never_done = 0;
    wait_valids(1, 100);
    check_eq("tmo_sticky", 32'(timeout_err), 1);

    // Ready never comes: timeout from trigger with no initiate at all.
    rd_hold_low = 1;
    apply_reset();
    c0 = cyc;
    i0 = n_init;
    wait_tmo(200);
    check_eq("trig_tmo_delay", tmo_rise_edge - c0, Period + Tmo);
    repeat (30) tick();
    check_eq("trig_tmo_no_init", n_init, i0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end", cyc);
    $fatal(1, "watchdog");
  end

endmodule
